// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: opcode values and FSM states.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer: shift-add multiply or restoring
// shift-subtract divide on magnitudes, selected by is_div.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        addend  = acc_lo[0] ? operand : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        // Partial remainder is WIDTH+1 bits wide once the next dividend bit is shifted in.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, operand});
        // When ge holds the true difference is below the divisor, so the low WIDTH bits are exact.
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            nxt_hi = ge ? diff : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per cycle,
// sign fixup in a final cycle, stall request while busy.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_hilo,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    function automatic logic [WIDTH-1:0] fix_word(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_dword(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div_q;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign busy      = (state != IDLE);
    assign stall_req = busy & (rd_hilo | start | wr_hi | wr_lo);

    // Operand capture: magnitudes are held unsigned, so -2^(WIDTH-1) keeps its full magnitude.
    always_comb begin
        sa     = src_a;
        sb     = src_b;
        sign_a = ~op[0] & (sa < 0);
        sign_b = ~op[0] & (sb < 0);
        mag_a  = fix_word(src_a, sign_a);
        mag_b  = fix_word(src_b, sign_b);
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .nxt_hi  (nxt_hi),
        .nxt_lo  (nxt_lo)
    );

    // Datapath registers carry no reset; they are always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            is_div_q <= op[1];
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= op[1] & (src_b == '0);
            raw_a    <= src_a;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? mag_a : mag_b;
            operand  <= op[1] ? mag_b : mag_a;
        end else if (state == CALC) begin
            acc_hi   <= nxt_hi;
            acc_lo   <= nxt_lo;
        end
    end

    // Sign correction applied in FIX; divide-by-zero bypasses it entirely.
    always_comb begin
        prod   = fix_dword({acc_hi, acc_lo}, neg_res);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero) begin
                res_hi = raw_a;
                res_lo = '1;
            end else begin
                res_hi = fix_word(acc_hi, neg_rem);
                res_lo = fix_word(acc_lo, neg_res);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!flush) begin
                            state <= CALC;
                            cnt   <= CNT_W'(WIDTH);
                        end
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, random ops against an
// arithmetic reference model, and hand-written stall/flush/reset sequences.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             rd_hilo;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t tbl[10];

    muldiv_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wr_data   (wr_data),
        .rd_hilo   (rd_hilo),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        int          sa;
        int          sb;
        longint      sp;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = a;
        sb = b;
        p  = '0;
        h  = '0;
        l  = '0;
        case (o)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                p  = sp;
                h  = p[63:32];
                l  = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (o == OP_DIV) begin
                    q = longint'(sa) / longint'(sb);
                    r = longint'(sa) % longint'(sb);
                    l = q[31:0];
                    h = r[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; stops at the first idle sample.
    task automatic wait_done(output int cyc, output bit early);
        cyc   = 0;
        early = 1'b0;
        while (busy && cyc < 200) begin
            if (done) early = 1'b1;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        bit early;
        issue(o, a, b);
        wait_done(cyc, early);
        chk({name, "_latency"}, cyc, 33);
        chk({name, "_early_done"}, {31'b0, early}, 0);
        chk({name, "_done"}, {31'b0, done}, 1);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'b0, done}, 0);
    endtask

    task automatic quiet_window(input string name, input int n, input logic [31:0] eh, input logic [31:0] el);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk({name, "_no_done"}, {31'b0, seen}, 0);
        chk({name, "_hi_kept"}, hi, eh);
        chk({name, "_lo_kept"}, lo, el);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] mh;
        logic [31:0] ml;
        int          k;
        int          cyc;
        bit          early;

        tbl[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        tbl[1] = '{OP_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m7x3"};
        tbl[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
        tbl[3] = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by0"};
        tbl[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
        tbl[5] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7dm2"};
        tbl[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin"};
        tbl[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7by0"};
        tbl[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF, "divu_big"};
        tbl[9] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         "multu_carry"};

        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; rd_hilo = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_stall", {31'b0, stall_req}, 0);
        rst = 1'b0;

        // MTHI then MTLO in IDLE.
        @(negedge clk); wr_hi = 1'b1; wr_data = 32'h1234;
        @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5678;
        @(negedge clk); wr_lo = 1'b0;
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h5678);

        for (int i = 0; i < 10; i++)
            run_check(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            model(ro, ra, rb, mh, ml);
            run_check($sformatf("rand%0d", i), ro, ra, rb, mh, ml);
        end

        // rd_hilo then a second start held during the busy window.
        issue(OP_MULTU, 32'd3, 32'd5);
        rd_hilo = 1'b1;
        k = 0;
        while (busy && k < 200) begin
            chk("stall_busy", {31'b0, stall_req}, 1);
            k++;
            if (k == 5) begin
                start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd7;
            end
            @(negedge clk);
        end
        chk("stall_first_latency", k, 33);
        chk("stall_first_done", {31'b0, done}, 1);
        chk("stall_first_lo", lo, 32'd15);
        chk("stall_idle_no_stall", {31'b0, stall_req}, 0);
        @(negedge clk);
        start = 1'b0; rd_hilo = 1'b0;
        wait_done(cyc, early);
        chk("second_latency", cyc, 33);
        chk("second_done", {31'b0, done}, 1);
        chk("second_lo", lo, 32'd142);
        chk("second_hi", hi, 32'd6);

        // Flush in the 10th CALC cycle.
        issue(OP_MULT, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_calc_busy", {31'b0, busy}, 0);
        quiet_window("flush_calc", 40, 32'd6, 32'd142);

        // Flush coincident with the FIX edge.
        issue(OP_DIVU, 32'd99, 32'd4);
        repeat (32) @(negedge clk);
        chk("fix_cycle_busy", {31'b0, busy}, 1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_fix_busy", {31'b0, busy}, 0);
        chk("flush_fix_done", {31'b0, done}, 0);
        quiet_window("flush_fix", 40, 32'd6, 32'd142);

        // Reset mid-CALC.
        issue(OP_MULTU, 32'd77, 32'd88);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 0);
        quiet_window("rst_mid", 40, 32'd0, 32'd0);

        // MTHI while busy is stalled and dropped.
        issue(OP_MULTU, 32'h10, 32'h20);
        wr_hi = 1'b1; wr_data = 32'hDEAD;
        chk("mthi_busy_stall", {31'b0, stall_req}, 1);
        @(negedge clk);
        chk("mthi_busy_hi", hi, 32'd0);
        wr_hi = 1'b0;
        wait_done(cyc, early);
        chk("mthi_busy_latency", cyc, 32);
        chk("mthi_busy_res_hi", hi, 32'd0);
        chk("mthi_busy_res_lo", lo, 32'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the pipelined CPU.
- Sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU from the decoder.
- Iterates one bit per cycle and writes HI/LO on completion.
- Raises a stall request to the hazard unit while it is busy, so dependent HI/LO reads and back-to-back mul/div are held in EX.

Parameters:
- WIDTH, 32, operand and HI/LO width; one iteration per bit.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  issue request from EX, qualified by the EX valid bit.
- op  input  2  op[1]: 0=multiply, 1=divide; op[0]: 1=unsigned, 0=signed.
- src_a  input  WIDTH  multiplicand / dividend (rs).
- src_b  input  WIDTH  multiplier / divisor (rt).
- wr_hi  input  1  MTHI write strobe.
- wr_lo  input  1  MTLO write strobe.
- wr_data  input  WIDTH  MTHI/MTLO data.
- rd_hilo  input  1  MFHI/MFLO in EX needs HI/LO this cycle.
- flush  input  1  pipeline flush; aborts any in-flight operation.
- busy  output  1  high whenever state != IDLE.
- stall_req  output  1  busy & (rd_hilo | start | wr_hi | wr_lo).
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  output  WIDTH  HI register (product high / remainder).
- lo  output  WIDTH  LO register (product low / quotient).

Behaviour:
- Reset: state=IDLE; counter=0; hi=0, lo=0, done=0, busy=0, stall_req=0. Reset mid-operation abandons the operation with no HI/LO write.

State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch |src_a| and |src_b| (raw operands if unsigned).
  - Latch the result-sign flags.
  - Load counter=WIDTH and go to CALC.
- CALC, edges E1..E_WIDTH:
  - One iteration per edge; counter decrements.
  - At counter==1, go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder WIDTH+1 bits, quotient WIDTH bits.
- FIX, edge E_WIDTH+1:
  - Apply sign correction and write hi/lo.
  - Set done=1 for the following cycle and return to IDLE.
- Latency: busy is high for exactly WIDTH+1 cycles after E0. New hi/lo and done appear together in the cycle after E_WIDTH+1, when busy is low.

Sign rules:
- Signed multiply: negate the 2*WIDTH product iff the operand signs differ.
- Signed divide: negate the quotient iff the signs differ; the remainder takes the sign of the dividend.
- Magnitude of the most-negative value is 2^(WIDTH-1), held unsigned. Signed -2^(WIDTH-1) / -1 gives lo=0x80000000 and hi=0 (wrap, no trap).

Divide by zero:
- Completes with the normal latency.
- Sets lo = all ones and hi = src_a as latched, with no sign fixup.

Start, writes and flush:
- start while busy: ignored. stall_req holds the instruction in EX and it re-issues once idle.
- MTHI/MTLO: accepted only in IDLE, write at the next edge. While busy they are ignored and stalled.
- wr_hi and wr_lo may be high together, writing both.
- start together with wr_hi/wr_lo in IDLE: start wins and the writes are dropped (the decoder never produces this).
- flush: CALC/FIX go to IDLE at the next edge, hi/lo unchanged, no done. flush takes priority over start in IDLE. flush coincident with the FIX edge still cancels the write.
- done is never asserted for aborted operations.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding constants: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - state encoding: IDLE, CALC, FIX.
- One sub-module, muldiv_step: a combinational single-iteration datapath (shift-add or shift-subtract, selected by op[1]). muldiv_seq owns the FSM, counter, sign logic and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 busy cycles: hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- rd_hilo and a second start asserted during CALC -> stall_req=1 every busy cycle. The second start is accepted only in the cycle busy drops, and its result appears 33 cycles later.
- Flush at the 10th CALC cycle, and separately at the FIX edge -> busy=0 next cycle, hi/lo keep prior values, done never set.
- rst pulse mid-CALC -> hi=lo=0, busy=0. MTHI 0x1234 then MTLO 0x5678 in IDLE -> hi=0x1234, lo=0x5678. MTHI while busy -> ignored, with stall_req=1.
